mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised, multi-cycle successor of the MEM pipeline stage in the RISC-V core. It accepts one instruction from EX/MEM and issues byte-lane-masked load/store requests to the data-memory port using a req/ack handshake. It aligns and sign- or zero-extends load data, and presents a registered writeback/forwarding result to MEM/WB. It stalls upstream while a memory transaction is outstanding and can split accesses that cross a bus word into two beats.

## Interface
- `XLEN`, 32: register/data width.
- `ADDR_W`, 32: address width.
- `BUS_W`, 32: memory data bus width; 32 or 64. Number of byte lanes `NB = BUS_W/8`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: EX/MEM presents an instruction.
- `in_ready` out 1: equals `state==IDLE`. The instruction transfers on `in_valid && in_ready && !rst`.
- `op` in 2: 00 pass-through, 01 load, 10 store, 11 treated as 00.
- `funct3` in 3: RISC-V width code. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr` in ADDR_W: effective address.
- `wdata_i` in XLEN: store data (store) or ALU result (pass-through).
- `wreg_i` in 1, `wd_i` in 5: register write enable and destination.
- `mem_req` out 1, `mem_we` out 1: request strobe and write select.
- `mem_addr` out ADDR_W: bus-word-aligned address (low log2(NB) bits are 0).
- `mem_be` out NB: byte enables.
- `mem_wdata` out BUS_W: lane-shifted store data.
- `mem_ack` in 1: completes the current beat.
- `mem_rdata` in BUS_W: read data, valid in the ack cycle.
- `out_valid` out 1: result valid, single-cycle pulse.
- `wreg_o` out 1, `wd_o` out 5, `wdata_o` out XLEN: writeback result; these are also the forwarding outputs.
- `misalign_o` out 1: misaligned-access flag, valid with `out_valid`.

## Operation
- Access size S is 1, 2 or 4 bytes. Offset `off = addr mod NB`. Base mask is `((1<<S)-1) << off`.
- Invalid `funct3` with load/store: no memory access. Completes like pass-through with `wreg_o=0` and `wdata_o=0`.
- FSM states and transitions:
  - IDLE → BEAT0 on accepting a load/store.
  - BEAT0 → BEAT1 on `mem_ack` when the access crosses a bus word; BEAT0 → IDLE on `mem_ack` otherwise.
  - BEAT1 → IDLE on `mem_ack`.
- `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata` are registered. They are held stable from the cycle after acceptance until the ack cycle, and go to 0 the cycle after the final ack. In the two-beat case they update to the BEAT1 values the cycle after the first ack.
- Store:
  - `mem_wdata = wdata_i << 8*off`, truncated to BUS_W.
  - `mem_we=1`.
  - Result: `wreg_o=0`, `wdata_o=0`.
- Load:
  - Bytes are collected from the enabled lanes and shifted down by `off`. BEAT1 supplies the upper bytes.
  - B/H are sign-extended; BU/HU are zero-extended; W is taken as is.
- Pass-through: no memory access; outputs are `wreg_i`, `wd_i`, `wdata_i`.
- `mem_ack` in IDLE is ignored.
- Accepted instruction fields are captured in registers; upstream inputs may change after acceptance.

## Timing
- Reset values: `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`, `out_valid`, `wreg_o`, `wd_o`, `wdata_o`, `misalign_o` are all 0. State is IDLE.
- Pass-through latency is 1 cycle, with throughput 1 instruction per cycle.
- Memory latency: `out_valid` asserts the cycle after the final `mem_ack`. The minimum is 2 cycles, with ack in the first request cycle.
- `in_ready` is low from the cycle after acceptance of a load/store until `out_valid`. It returns high in the same cycle as `out_valid`, so a new instruction can be accepted that cycle.
- Downstream has no backpressure; MEM/WB always accepts.
- Reset mid-transaction: on the next edge, state goes to IDLE, `mem_req` goes to 0, and no `out_valid` is produced. A late ack is ignored.

## Configuration
- `MEM_MISALIGN_SPLIT_EN` defined: when `off+S > NB`, the access is split.
  - BEAT0: base address, lanes off..NB-1.
  - BEAT1: base+NB, lanes 0..off+S-NB-1.
  - `misalign_o` is always 0.
- `MEM_MISALIGN_SPLIT_EN` undefined: a crossing access issues no request and completes in 1 cycle with `out_valid=1`, `misalign_o=1`, `wreg_o=0`, `wdata_o=0`.
- Non-crossing unaligned accesses (e.g. LH at 0x101 with BUS_W=32) are single-beat in both builds.

## Test plan
- LW 0x100, ack 2 cycles after req, rdata 0xDEADBEEF:
  - `mem_addr=0x100`, `mem_be=1111`.
  - `wdata_o=0xDEADBEEF` and `out_valid` one cycle after ack.
- LB 0x103, rdata 0x80123456:
  - `mem_be=1000`, `wdata_o=0xFFFFFF80`.
  - LBU with the same stimulus gives 0x00000080.
- SH 0x102, `wdata_i=0x1234ABCD`:
  - `mem_we=1`, `mem_be=1100`, `mem_wdata=0xABCD0000`, `wreg_o=0`.
- LW 0x102 with the macro:
  - BEAT0: addr 0x100, be 1100, rdata 0x55660000.
  - BEAT1: addr 0x104, be 0011, rdata 0x00007788.
  - Result `wdata_o=0x77885566`.
  - Without the macro: no `mem_req`, `misalign_o=1`, `wreg_o=0`.
- Three consecutive pass-through ops, x5/x6/x7 with 1/2/3:
  - Three consecutive `out_valid` pulses with matching `wd_o`/`wdata_o`.
  - `in_ready` stays 1 throughout.
- `rst` pulsed while in BEAT0, then `mem_ack` the cycle after reset:
  - `mem_req=0` after the edge.
  - No `out_valid` for that op.
  - `in_ready=1`.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle MEM stage. Issues byte-lane-masked load/store
// requests over a req/ack data port, aligns and extends load data, and
// presents a registered writeback/forwarding result to MEM/WB.
// Build option MEM_MISALIGN_SPLIT_EN: when defined, accesses that cross a bus
// word are split into two beats; when undefined they complete at once with
// misalign_o set and no memory request.
module mem_access_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned BUS_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [2:0]           funct3,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [XLEN-1:0]      wdata_i,
    input  logic                 wreg_i,
    input  logic [4:0]           wd_i,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [BUS_W/8-1:0]   mem_be,
    output logic [BUS_W-1:0]     mem_wdata,
    input  logic                 mem_ack,
    input  logic [BUS_W-1:0]     mem_rdata,
    output logic                 out_valid,
    output logic                 wreg_o,
    output logic [4:0]           wd_o,
    output logic [XLEN-1:0]      wdata_o,
    output logic                 misalign_o
);
    localparam int unsigned NB    = BUS_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned CNT_W = OFF_W + 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [NB-1:0]      mem_be_q, mem_be_d;
    logic [BUS_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic               out_valid_q, out_valid_d;
    logic               wreg_o_q, wreg_o_d;
    logic [4:0]         wd_o_q, wd_o_d;
    logic [XLEN-1:0]    wdata_o_q, wdata_o_d;
    logic               misalign_q, misalign_d;

    // captured instruction fields
    logic [2:0]         f3_q, f3_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [4:0]         wd_q, wd_d;
    logic               wreg_q, wreg_d;
    logic               store_q, store_d;

`ifdef MEM_MISALIGN_SPLIT_EN
    logic               split_q, split_d;
    logic [NB-1:0]      be_hi_q, be_hi_d;
    logic [BUS_W-1:0]   st_hi_q, st_hi_d;
    logic [XLEN-1:0]    lo_q, lo_d;
    logic [NB-1:0]      be_hi;
    logic [BUS_W-1:0]   st_hi;
    logic [OFF_W:0]     hi_sh;
    logic [XLEN-1:0]    ld_hi;
`endif

    logic               is_mem;
    logic               is_store;
    logic               f3_ok;
    logic               crossing;
    logic [2:0]         size;
    logic [OFF_W-1:0]   off;
    logic [NB-1:0]      be_lo;
    logic [BUS_W-1:0]   st_lo;
    logic [XLEN-1:0]    ld_lo;
    logic [XLEN-1:0]    ld_data;
    logic               done;

    // Sign/zero extension of aligned load data by width code
    function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] d,
                                                 input logic [2:0]      f3);
        case (f3)
            3'b000:  load_ext = {{(XLEN-8){d[7]}}, d[7:0]};
            3'b001:  load_ext = {{(XLEN-16){d[15]}}, d[15:0]};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, d[7:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, d[15:0]};
            default: load_ext = d;
        endcase
    endfunction

    // Decode the presented instruction: size, lane offset, masks, store data
    always_comb begin
        is_mem   = (op == 2'b01) || (op == 2'b10);
        is_store = (op == 2'b10);
        off      = addr[OFF_W-1:0];
        f3_ok    = 1'b1;
        size     = 3'd1;
        case (funct3)
            3'b000, 3'b100: size = 3'd1;
            3'b001, 3'b101: size = 3'd2;
            3'b010:         size = 3'd4;
            default:        f3_ok = 1'b0;
        endcase
        crossing = (CNT_W'(off) + CNT_W'(size)) > CNT_W'(NB);
        be_lo    = NB'(((32'd1 << size) - 32'd1) << off);
        st_lo    = BUS_W'((2 * BUS_W)'(wdata_i) << {off, 3'b000});
`ifdef MEM_MISALIGN_SPLIT_EN
        be_hi    = NB'((((32'd1 << size) - 32'd1) << off) >> NB);
        st_hi    = BUS_W'(((2 * BUS_W)'(wdata_i) << {off, 3'b000}) >> BUS_W);
`endif
    end

    // Align returned bus data down to byte 0 of the result
    always_comb begin
        ld_lo = XLEN'(mem_rdata >> {off_q, 3'b000});
`ifdef MEM_MISALIGN_SPLIT_EN
        hi_sh = (OFF_W + 1)'(NB) - (OFF_W + 1)'(off_q);
        ld_hi = XLEN'((BUS_W + XLEN)'(mem_rdata) << {hi_sh, 3'b000});
`endif
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        out_valid_d = 1'b0;
        wreg_o_d    = wreg_o_q;
        wd_o_d      = wd_o_q;
        wdata_o_d   = wdata_o_q;
        misalign_d  = misalign_q;
        f3_d        = f3_q;
        off_d       = off_q;
        wd_d        = wd_q;
        wreg_d      = wreg_q;
        store_d     = store_q;
`ifdef MEM_MISALIGN_SPLIT_EN
        split_d     = split_q;
        be_hi_d     = be_hi_q;
        st_hi_d     = st_hi_q;
        lo_d        = lo_q;
`endif
        done        = 1'b0;
        ld_data     = ld_lo;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        out_valid_d = 1'b1;
                        wreg_o_d    = wreg_i;
                        wd_o_d      = wd_i;
                        wdata_o_d   = wdata_i;
                        misalign_d  = 1'b0;
                    end else if (!f3_ok) begin
                        out_valid_d = 1'b1;
                        wreg_o_d    = 1'b0;
                        wd_o_d      = wd_i;
                        wdata_o_d   = '0;
                        misalign_d  = 1'b0;
`ifndef MEM_MISALIGN_SPLIT_EN
                    end else if (crossing) begin
                        out_valid_d = 1'b1;
                        wreg_o_d    = 1'b0;
                        wd_o_d      = wd_i;
                        wdata_o_d   = '0;
                        misalign_d  = 1'b1;
`endif
                    end else begin
                        state_d     = BEAT0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                        mem_be_d    = be_lo;
                        mem_wdata_d = is_store ? st_lo : '0;
                        f3_d        = funct3;
                        off_d       = off;
                        wd_d        = wd_i;
                        wreg_d      = wreg_i;
                        store_d     = is_store;
`ifdef MEM_MISALIGN_SPLIT_EN
                        split_d     = crossing;
                        be_hi_d     = be_hi;
                        st_hi_d     = is_store ? st_hi : '0;
`endif
                    end
                end
            end
            BEAT0: begin
                if (mem_ack) begin
`ifdef MEM_MISALIGN_SPLIT_EN
                    if (split_q) begin
                        state_d     = BEAT1;
                        mem_addr_d  = mem_addr_q + ADDR_W'(NB);
                        mem_be_d    = be_hi_q;
                        mem_wdata_d = st_hi_q;
                        lo_d        = ld_lo;
                    end else begin
                        done = 1'b1;
                    end
`else
                    done = 1'b1;
`endif
                end
            end
            BEAT1: begin
`ifdef MEM_MISALIGN_SPLIT_EN
                // second beat supplies the upper bytes of the result
                ld_data = lo_q | ld_hi;
                if (mem_ack) begin
                    done = 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            state_d     = IDLE;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_be_d    = '0;
            mem_wdata_d = '0;
            out_valid_d = 1'b1;
            wreg_o_d    = store_q ? 1'b0 : wreg_q;
            wd_o_d      = wd_q;
            wdata_o_d   = store_q ? '0 : load_ext(ld_data, f3_q);
            misalign_d  = 1'b0;
        end
    end

    // State, bus and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            out_valid_q <= 1'b0;
            wreg_o_q    <= 1'b0;
            wd_o_q      <= '0;
            wdata_o_q   <= '0;
            misalign_q  <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
            wd_q        <= '0;
            wreg_q      <= 1'b0;
            store_q     <= 1'b0;
`ifdef MEM_MISALIGN_SPLIT_EN
            split_q     <= 1'b0;
            be_hi_q     <= '0;
            st_hi_q     <= '0;
            lo_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            out_valid_q <= out_valid_d;
            wreg_o_q    <= wreg_o_d;
            wd_o_q      <= wd_o_d;
            wdata_o_q   <= wdata_o_d;
            misalign_q  <= misalign_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            wd_q        <= wd_d;
            wreg_q      <= wreg_d;
            store_q     <= store_d;
`ifdef MEM_MISALIGN_SPLIT_EN
            split_q     <= split_d;
            be_hi_q     <= be_hi_d;
            st_hi_q     <= st_hi_d;
            lo_q        <= lo_d;
`endif
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign out_valid  = out_valid_q;
    assign wreg_o     = wreg_o_q;
    assign wd_o       = wd_o_q;
    assign wdata_o    = wdata_o_q;
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit (BUS_W=32): a memory responder checks
// request beats and returns data; a monitor checks each out_valid result.
module tb_mem_access_unit;
    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_LD   = 2'b01;
    localparam logic [1:0] OP_ST   = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata_i;
    logic        wreg_i;
    logic [4:0]  wd_i;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        wreg_o;
    logic [4:0]  wd_o;
    logic [31:0] wdata_o;
    logic        misalign_o;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
    } beat_t;

    typedef struct {
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        mis;
        logic        memop;
    } res_t;

    beat_t beat_q[$];
    res_t  res_q[$];
    int    checks = 0;
    int    failures = 0;
    logic  ack_edge = 1'b0;

    mem_access_unit #(.XLEN(32), .ADDR_W(32), .BUS_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .funct3     (funct3),
        .addr       (addr),
        .wdata_i    (wdata_i),
        .wreg_i     (wreg_i),
        .wd_i       (wd_i),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .wreg_o     (wreg_o),
        .wd_o       (wd_o),
        .wdata_o    (wdata_o),
        .misalign_o (misalign_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ack_edge <= mem_ack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic we, input logic [31:0] a, input logic [3:0] be,
                             input logic [31:0] wd, input logic [31:0] rd, input int dly);
        beat_t b;
        b.we = we; b.addr = a; b.be = be; b.wdata = wd; b.rdata = rd; b.delay = dly;
        beat_q.push_back(b);
    endtask

    task automatic push_res(input logic wr, input logic [4:0] rd, input logic [31:0] d,
                            input logic mis, input logic memop);
        res_t r;
        r.wreg = wr; r.wd = rd; r.wdata = d; r.mis = mis; r.memop = memop;
        res_q.push_back(r);
    endtask

    task automatic issue(input logic [1:0] o, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic wr, input logic [4:0] rd);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b1; op = o; funct3 = f3; addr = a; wdata_i = d; wreg_i = wr; wd_i = rd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(in_ready && res_q.size() == 0 && beat_q.size() == 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    // Memory responder: checks each request beat and acks after its delay
    initial begin
        beat_t b;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_mem_req", 32'd1, 32'd0);
                end else begin
                    b = beat_q.pop_front();
                    chk("req_addr", mem_addr, b.addr);
                    chk("req_be", 32'(mem_be), 32'(b.be));
                    chk("req_we", 32'(mem_we), 32'(b.we));
                    if (b.we) chk("req_wdata", mem_wdata, b.wdata);
                    repeat (b.delay) @(negedge clk);
                    mem_ack = 1'b1;
                    mem_rdata = b.rdata;
                end
            end
        end
    end

    // Result monitor: pops the expected result on every out_valid pulse
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    r = res_q.pop_front();
                    chk("out_wreg", 32'(wreg_o), 32'(r.wreg));
                    if (r.wreg) chk("out_wd", 32'(wd_o), 32'(r.wd));
                    chk("out_wdata", wdata_o, r.wdata);
                    chk("out_misalign", 32'(misalign_o), 32'(r.mis));
                    if (r.memop) chk("ack_to_out_valid_latency", 32'(ack_edge), 32'd1);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = '0; funct3 = '0; addr = '0;
        wdata_i = '0; wreg_i = 1'b0; wd_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_wreg_o", 32'(wreg_o), 32'd0);
        chk("rst_wd_o", 32'(wd_o), 32'd0);
        chk("rst_wdata_o", wdata_o, 32'd0);
        chk("rst_misalign_o", 32'(misalign_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // LW 0x100, ack two cycles after request
        push_beat(1'b0, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 2);
        push_res(1'b1, 5'd10, 32'hDEADBEEF, 1'b0, 1'b1);
        issue(OP_LD, 3'b010, 32'h100, 32'h0, 1'b1, 5'd10);
        @(negedge clk);
        chk("ld_in_ready_low", 32'(in_ready), 32'd0);

        // LB / LBU 0x103
        push_beat(1'b0, 32'h100, 4'b1000, 32'h0, 32'h80123456, 0);
        push_res(1'b1, 5'd11, 32'hFFFFFF80, 1'b0, 1'b1);
        issue(OP_LD, 3'b000, 32'h103, 32'h0, 1'b1, 5'd11);
        push_beat(1'b0, 32'h100, 4'b1000, 32'h0, 32'h80123456, 1);
        push_res(1'b1, 5'd12, 32'h00000080, 1'b0, 1'b1);
        issue(OP_LD, 3'b100, 32'h103, 32'h0, 1'b1, 5'd12);

        // SH 0x102 and SB 0x101
        push_beat(1'b1, 32'h100, 4'b1100, 32'hABCD0000, 32'h0, 0);
        push_res(1'b0, 5'd13, 32'h0, 1'b0, 1'b1);
        issue(OP_ST, 3'b001, 32'h102, 32'h1234ABCD, 1'b1, 5'd13);
        push_beat(1'b1, 32'h100, 4'b0010, 32'h3456A500, 32'h0, 1);
        push_res(1'b0, 5'd13, 32'h0, 1'b0, 1'b1);
        issue(OP_ST, 3'b000, 32'h101, 32'h123456A5, 1'b1, 5'd13);

        // non-crossing unaligned LH 0x101, LHU 0x202
        push_beat(1'b0, 32'h100, 4'b0110, 32'h0, 32'h12ABCD34, 0);
        push_res(1'b1, 5'd14, 32'hFFFFABCD, 1'b0, 1'b1);
        issue(OP_LD, 3'b001, 32'h101, 32'h0, 1'b1, 5'd14);
        push_beat(1'b0, 32'h200, 4'b1100, 32'h0, 32'h8001FFFF, 0);
        push_res(1'b1, 5'd15, 32'h00008001, 1'b0, 1'b1);
        issue(OP_LD, 3'b101, 32'h202, 32'h0, 1'b1, 5'd15);

        // word-crossing accesses
`ifdef MEM_MISALIGN_SPLIT_EN
        push_beat(1'b0, 32'h100, 4'b1100, 32'h0, 32'h55660000, 0);
        push_beat(1'b0, 32'h104, 4'b0011, 32'h0, 32'h00007788, 1);
        push_res(1'b1, 5'd16, 32'h77885566, 1'b0, 1'b1);
        issue(OP_LD, 3'b010, 32'h102, 32'h0, 1'b1, 5'd16);
        push_beat(1'b1, 32'h100, 4'b1000, 32'h44000000, 32'h0, 0);
        push_beat(1'b1, 32'h104, 4'b0111, 32'h00112233, 32'h0, 0);
        push_res(1'b0, 5'd17, 32'h0, 1'b0, 1'b1);
        issue(OP_ST, 3'b010, 32'h103, 32'h11223344, 1'b1, 5'd17);
        push_beat(1'b0, 32'h100, 4'b1000, 32'h0, 32'hAB000000, 0);
        push_beat(1'b0, 32'h104, 4'b0001, 32'h0, 32'hFFFFFFCD, 0);
        push_res(1'b1, 5'd18, 32'hFFFFCDAB, 1'b0, 1'b1);
        issue(OP_LD, 3'b001, 32'h103, 32'h0, 1'b1, 5'd18);
`else
        push_res(1'b0, 5'd16, 32'h0, 1'b1, 1'b0);
        issue(OP_LD, 3'b010, 32'h102, 32'h0, 1'b1, 5'd16);
        push_res(1'b0, 5'd17, 32'h0, 1'b1, 1'b0);
        issue(OP_ST, 3'b010, 32'h103, 32'h11223344, 1'b1, 5'd17);
        push_res(1'b0, 5'd18, 32'h0, 1'b1, 1'b0);
        issue(OP_LD, 3'b001, 32'h103, 32'h0, 1'b1, 5'd18);
`endif

        // invalid funct3 load, and op=11 as pass-through
        push_res(1'b0, 5'd19, 32'h0, 1'b0, 1'b0);
        issue(OP_LD, 3'b011, 32'h100, 32'h0, 1'b1, 5'd19);
        push_res(1'b1, 5'd20, 32'hCAFEF00D, 1'b0, 1'b0);
        issue(2'b11, 3'b010, 32'h100, 32'hCAFEF00D, 1'b1, 5'd20);

        // three back-to-back pass-throughs x5/x6/x7
        wait_idle();
        for (int k = 0; k < 3; k++) begin
            push_res(1'b1, 5'(5 + k), 32'(k + 1), 1'b0, 1'b0);
            @(negedge clk);
            chk("pt_in_ready", 32'(in_ready), 32'd1);
            if (k > 0) chk("pt_out_valid_b2b", 32'(out_valid), 32'd1);
            in_valid = 1'b1; op = OP_PASS; funct3 = 3'b000; addr = 32'h0;
            wdata_i = 32'(k + 1); wreg_i = 1'b1; wd_i = 5'(5 + k);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("pt_out_valid_last", 32'(out_valid), 32'd1);
        chk("pt_in_ready_last", 32'(in_ready), 32'd1);

        // reset while in BEAT0, then a late ack the cycle after reset
        wait_idle();
        push_beat(1'b0, 32'h300, 4'b1111, 32'h0, 32'h12345678, 1);
        @(negedge clk);
        in_valid = 1'b1; op = OP_LD; funct3 = 3'b010; addr = 32'h300;
        wdata_i = 32'h0; wreg_i = 1'b1; wd_i = 5'd21;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_pre_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_mem_req", 32'(mem_req), 32'd0);
        chk("rstmid_in_ready", 32'(in_ready), 32'd1);
        chk("rstmid_out_valid", 32'(out_valid), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("rstmid_no_out_valid", 32'(out_valid), 32'd0);
            chk("rstmid_no_req", 32'(mem_req), 32'd0);
        end

        // recovery after reset
        push_beat(1'b0, 32'h400, 4'b1111, 32'h0, 32'h0BADF00D, 0);
        push_res(1'b1, 5'd22, 32'h0BADF00D, 1'b0, 1'b1);
        issue(OP_LD, 3'b010, 32'h400, 32'h0, 1'b1, 5'd22);

        wait_idle();
        repeat (2) @(negedge clk);
        chk("beat_queue_empty", 32'(beat_q.size()), 32'd0);
        chk("result_queue_empty", 32'(res_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
